snn_spike_classifier: RTL and testbench
=======================================

Name: snn_spike_classifier

Overview:
- Downstream consumer of the SNN core output stream (packet_out / packet_out_valid).
- Per frame, records which output neurons fired, counts distinct spikes per class, and reports the winning class (argmax) once the core signals the frame is finished.
- Replaces software-side spike_out comparison with an on-chip classification result readable by the SoC.

Parameters:
- NUM_OUTPUT, 250, number of output neurons (valid packet_out indices 0..NUM_OUTPUT-1)
- NUM_CLASS, 10, number of classes; neuron idx belongs to class idx % NUM_CLASS
- IDX_W, 8, width of packet_out
- CLASS_W, 4, width of class index (ceil(log2(NUM_CLASS)))
- CNT_W, 6, width of per-class vote counter (saturating)

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse; clears the spike vector and counters and starts a new frame (drive from tick)
- frame_done  in  1  single-cycle pulse; core finished the frame, start argmax
- packet_out  in  IDX_W  output neuron index of a spike
- packet_out_valid  in  1  packet_out is valid this cycle; one spike per high cycle
- spike_vector  out  NUM_OUTPUT  bit (NUM_OUTPUT-1-idx) set when neuron idx fired this frame
- class_valid  out  1  one-cycle pulse: class_id/class_votes updated
- class_id  out  CLASS_W  winning class of the last completed frame
- class_votes  out  CNT_W  vote count of the winning class
- busy  out  1  high while in SCAN
- range_err  out  1  sticky: packet_out >= NUM_OUTPUT seen
- late_err  out  1  sticky: spike arrived during SCAN

Behaviour:
- Reset: all outputs 0, all counters 0, FSM = COLLECT. Sticky errors clear only on reset.
- FSM states:
  - COLLECT: accept spikes; frame_done -> SCAN with scan index 0, best = 0, best_votes = 0.
  - SCAN: one class per cycle. If cnt[k] > best_votes (strict), update best = k and best_votes = cnt[k]. After k = NUM_CLASS-1 -> REPORT.
  - REPORT: class_valid = 1 for one cycle; class_id/class_votes loaded; -> COLLECT.
- Latency: frame_done high in cycle T -> class_valid high in cycle T+NUM_CLASS+1. class_id/class_votes hold until the next REPORT.
- Ties: the lowest class index wins. All-zero counts give class_id = 0, class_votes = 0.
- Spike accept (COLLECT, valid = 1, idx < NUM_OUTPUT):
  - If the spike_vector bit is clear, set it and increment cnt[idx % NUM_CLASS] (saturating at 2^CNT_W-1).
  - If the bit is already set, it is a duplicate: no count change, no error.
- idx >= NUM_OUTPUT: ignored; range_err set.
- Spike during SCAN or REPORT: ignored; late_err set.
- frame_start (any state): next cycle spike_vector = 0, counters = 0, FSM = COLLECT (aborts SCAN, no class_valid). class_id/class_votes keep their old values.
- frame_start and valid in the same cycle: clear takes priority; that spike is then applied on top, so the new frame starts with that bit set and its class count = 1.
- frame_done and valid in the same cycle in COLLECT: the spike is counted, then SCAN starts.
- frame_done while in SCAN/REPORT is ignored.
- The idx % NUM_CLASS mapping is combinational and must close timing in one cycle at core clock.

Test Plan:
- Reset mid-SCAN (assert reset_n=0 at T+3 after frame_done) -> class_valid never pulses; all outputs 0, FSM back in COLLECT.
- frame_start; spikes idx 3, 13, 23, 7; frame_done at T -> class_valid at T+11, class_id=3, class_votes=3; spike_vector bits 246, 236, 226, 242 set.
- Tie: spikes idx 5, 15, 2, 12 -> class_id=2, class_votes=2 (lower index wins).
- Duplicate and out-of-range: idx 4 sent three times, then idx 250 -> cnt[4]=1, class_id=4, class_votes=1, range_err=1.
- Spike idx 9 two cycles after frame_done -> late_err=1, class_id=0 with class_votes=0 (no other spikes in the frame).
- frame_start coincident with a valid idx 1, after a frame that had 20 spikes -> spike_vector has only bit 248 set; a following frame_done yields class_id=1, class_votes=1.

Source files
------------

// File: rtl/snn_spike_classifier_if.sv
// Spike-stream input and classification-result bus between the SNN core
// side (master) and the classifier (slave).
interface snn_spike_classifier_if #(
    parameter int NUM_OUTPUT = 250,
    parameter int IDX_W      = 8,
    parameter int CLASS_W    = 4,
    parameter int CNT_W      = 6
);
    logic                  frame_start;
    logic                  frame_done;
    logic [IDX_W-1:0]      packet_out;
    logic                  packet_out_valid;
    logic [NUM_OUTPUT-1:0] spike_vector;
    logic                  class_valid;
    logic [CLASS_W-1:0]    class_id;
    logic [CNT_W-1:0]      class_votes;
    logic                  busy;
    logic                  range_err;
    logic                  late_err;

    modport slave (
        input  frame_start, frame_done, packet_out, packet_out_valid,
        output spike_vector, class_valid, class_id, class_votes,
               busy, range_err, late_err
    );

    modport master (
        output frame_start, frame_done, packet_out, packet_out_valid,
        input  spike_vector, class_valid, class_id, class_votes,
               busy, range_err, late_err
    );
endinterface

// File: rtl/snn_spike_classifier.sv
// Per-frame spike recorder and argmax classifier for the SNN output stream.
// COLLECT records distinct spikes and per-class votes, SCAN walks one class
// per cycle keeping the strict maximum (lowest index wins ties), REPORT
// pulses class_valid with the winner.
module snn_spike_classifier #(
    parameter int NUM_OUTPUT = 250,
    parameter int NUM_CLASS  = 10,
    parameter int IDX_W      = 8,
    parameter int CLASS_W    = 4,
    parameter int CNT_W      = 6
) (
    input logic                    clk,
    input logic                    reset_n,
    snn_spike_classifier_if.slave  bus
);
    typedef enum logic [1:0] {COLLECT, SCAN, REPORT} state_t;

    state_t                state, state_next;
    logic [NUM_OUTPUT-1:0] vec, vec_next, hit;
    logic [CNT_W-1:0]      cnt      [NUM_CLASS];
    logic [CNT_W-1:0]      cnt_next [NUM_CLASS];
    logic [CLASS_W-1:0]    cls, scan_idx, best, best_next, class_id;
    logic [CNT_W-1:0]      best_votes, votes_next, class_votes;
    logic                  in_range, accept, is_new, last_k;
    logic                  range_err, late_err;

    // Decode the incoming spike: one-hot bit position, class and acceptance.
    // A frame_start in the same cycle opens the new frame, so the spike is
    // accepted on top of the cleared state whatever the current state is.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_OUTPUT; i++)
            hit[NUM_OUTPUT-1-i] = (bus.packet_out == IDX_W'(i));
        in_range = bus.packet_out < IDX_W'(NUM_OUTPUT);
        cls      = CLASS_W'(bus.packet_out % IDX_W'(NUM_CLASS));
        accept   = bus.packet_out_valid && in_range &&
                   (bus.frame_start || state == COLLECT);
        is_new   = bus.frame_start || ((hit & vec) == '0);
        vec_next = bus.frame_start ? '0 : vec;
        if (accept)
            vec_next = vec_next | hit;
        for (int c = 0; c < NUM_CLASS; c++) begin
            cnt_next[c] = bus.frame_start ? '0 : cnt[c];
            if (accept && is_new && cls == CLASS_W'(c) && cnt_next[c] != '1)
                cnt_next[c] = cnt_next[c] + 1'b1;
        end
    end

    // Argmax step for the class under scan; strict compare keeps lowest index on ties.
    always_comb begin
        last_k     = scan_idx == CLASS_W'(NUM_CLASS - 1);
        best_next  = best;
        votes_next = best_votes;
        if (cnt[scan_idx] > best_votes) begin
            best_next  = scan_idx;
            votes_next = cnt[scan_idx];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= COLLECT;
        else          state <= state_next;
    end

    // Next-state logic; frame_start aborts any frame in progress.
    always_comb begin
        state_next = state;
        if (bus.frame_start) begin
            state_next = COLLECT;
        end else begin
            case (state)
                COLLECT: if (bus.frame_done) state_next = SCAN;
                SCAN:    if (last_k)         state_next = REPORT;
                REPORT:                      state_next = COLLECT;
                default:                     state_next = COLLECT;
            endcase
        end
    end

    // Spike vector and vote counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec <= '0;
            for (int c = 0; c < NUM_CLASS; c++) cnt[c] <= '0;
        end else begin
            vec <= vec_next;
            for (int c = 0; c < NUM_CLASS; c++) cnt[c] <= cnt_next[c];
        end
    end

    // Scan bookkeeping and result latch; an aborted scan leaves the result untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx    <= '0;
            best        <= '0;
            best_votes  <= '0;
            class_id    <= '0;
            class_votes <= '0;
        end else if (state == COLLECT && bus.frame_done && !bus.frame_start) begin
            scan_idx   <= '0;
            best       <= '0;
            best_votes <= '0;
        end else if (state == SCAN) begin
            scan_idx   <= scan_idx + 1'b1;
            best       <= best_next;
            best_votes <= votes_next;
            if (last_k && !bus.frame_start) begin
                class_id    <= best_next;
                class_votes <= votes_next;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            range_err <= 1'b0;
            late_err  <= 1'b0;
        end else begin
            if (bus.packet_out_valid && !in_range)
                range_err <= 1'b1;
            if (bus.packet_out_valid && !bus.frame_start && state != COLLECT)
                late_err <= 1'b1;
        end
    end

    assign bus.spike_vector = vec;
    assign bus.class_valid  = state == REPORT;
    assign bus.busy         = state == SCAN;
    assign bus.class_id     = class_id;
    assign bus.class_votes  = class_votes;
    assign bus.range_err    = range_err;
    assign bus.late_err     = late_err;
endmodule

// File: tb/tb_snn_spike_classifier.sv
// Directed bench for snn_spike_classifier: one task per scenario, inline checks.
module tb_snn_spike_classifier;
    localparam int NUM_OUTPUT = 250;
    localparam int NUM_CLASS  = 10;
    localparam int IDX_W      = 8;
    localparam int CLASS_W    = 4;
    localparam int CNT_W      = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    snn_spike_classifier_if #(.NUM_OUTPUT(NUM_OUTPUT), .IDX_W(IDX_W),
                              .CLASS_W(CLASS_W), .CNT_W(CNT_W)) bus ();

    snn_spike_classifier #(.NUM_OUTPUT(NUM_OUTPUT), .NUM_CLASS(NUM_CLASS),
                           .IDX_W(IDX_W), .CLASS_W(CLASS_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic spike(input int idx);
        bus.packet_out       = IDX_W'(idx);
        bus.packet_out_valid = 1'b1;
        step();
        bus.packet_out_valid = 1'b0;
    endtask

    // Pulse frame_done (cycle T), then count cycles until class_valid; returns T+n offset.
    task automatic finish_frame(output int cyc);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        cyc = 1;
        while (!bus.class_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input int exp_cyc, input int cyc,
                                input int exp_id, input int exp_votes);
        checks++;
        if (cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s latency got T+%0d want T+%0d", name, cyc, exp_cyc);
        end
        checks++;
        if (bus.class_id !== CLASS_W'(exp_id)) begin
            errors++;
            $display("FAIL %s class_id got %0d want %0d", name, bus.class_id, exp_id);
        end
        checks++;
        if (bus.class_votes !== CNT_W'(exp_votes)) begin
            errors++;
            $display("FAIL %s class_votes got %0d want %0d", name, bus.class_votes, exp_votes);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (bus.spike_vector !== '0 || bus.class_valid !== 1'b0 || bus.class_id !== '0 ||
            bus.class_votes !== '0 || bus.busy !== 1'b0 || bus.range_err !== 1'b0 ||
            bus.late_err !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs not zero: vec_nz=%0b valid=%0b id=%0d votes=%0d busy=%0b rerr=%0b lerr=%0b want all 0",
                     name, bus.spike_vector != '0, bus.class_valid, bus.class_id,
                     bus.class_votes, bus.busy, bus.range_err, bus.late_err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        step();
        reset_n = 1'b1;
        step();
        check_outputs_zero("after_reset");
    endtask

    task automatic test_basic();
        logic [NUM_OUTPUT-1:0] exp_vec;
        int cyc;
        exp_vec = '0;
        exp_vec[246] = 1'b1;
        exp_vec[236] = 1'b1;
        exp_vec[226] = 1'b1;
        exp_vec[242] = 1'b1;
        start_frame();
        spike(3); spike(13); spike(23); spike(7);
        checks++;
        if (bus.spike_vector !== exp_vec) begin
            errors++;
            $display("FAIL basic spike_vector got %h want %h", bus.spike_vector, exp_vec);
        end
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic busy got %0b want 1", bus.busy);
        end
        cyc = 1;
        while (!bus.class_valid && cyc < 40) begin
            step();
            cyc++;
        end
        check_result("basic", 11, cyc, 3, 3);
        step();
        checks++;
        if (bus.class_valid !== 1'b0 || bus.class_id !== CLASS_W'(3)) begin
            errors++;
            $display("FAIL basic_hold valid=%0b id=%0d want valid 0 id 3", bus.class_valid, bus.class_id);
        end
    endtask

    task automatic test_tie();
        int cyc;
        start_frame();
        spike(5); spike(15); spike(2); spike(12);
        finish_frame(cyc);
        check_result("tie", 11, cyc, 2, 2);
    endtask

    task automatic test_dup_range();
        int cyc;
        start_frame();
        spike(4); spike(4); spike(4); spike(250);
        finish_frame(cyc);
        check_result("dup_range", 11, cyc, 4, 1);
        checks++;
        if (bus.range_err !== 1'b1 || bus.late_err !== 1'b0) begin
            errors++;
            $display("FAIL dup_range errs range=%0b late=%0b want 1 0", bus.range_err, bus.late_err);
        end
    endtask

    task automatic test_late();
        int cyc;
        start_frame();
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        step();
        spike(9);
        cyc = 3;
        while (!bus.class_valid && cyc < 40) begin
            step();
            cyc++;
        end
        check_result("late", 11, cyc, 0, 0);
        checks++;
        if (bus.late_err !== 1'b1 || bus.spike_vector !== '0) begin
            errors++;
            $display("FAIL late late_err=%0b vec_nz=%0b want 1 0", bus.late_err, bus.spike_vector != '0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_frame();
        spike(8);
        bus.packet_out       = IDX_W'(18);
        bus.packet_out_valid = 1'b1;
        finish_frame(cyc);
        bus.packet_out_valid = 1'b0;
        check_result("done_with_spike", 11, cyc, 8, 2);
    endtask

    task automatic test_start_with_spike();
        logic [NUM_OUTPUT-1:0] exp_vec;
        int cyc;
        exp_vec = '0;
        exp_vec[248] = 1'b1;
        start_frame();
        for (int i = 100; i < 120; i++) spike(i);
        bus.frame_start      = 1'b1;
        bus.packet_out       = IDX_W'(1);
        bus.packet_out_valid = 1'b1;
        step();
        bus.frame_start      = 1'b0;
        bus.packet_out_valid = 1'b0;
        checks++;
        if (bus.spike_vector !== exp_vec) begin
            errors++;
            $display("FAIL start_spike spike_vector got %h want %h", bus.spike_vector, exp_vec);
        end
        finish_frame(cyc);
        check_result("start_spike", 11, cyc, 1, 1);
    endtask

    task automatic test_reset_mid_scan();
        int pulses;
        start_frame();
        spike(6); spike(16);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_scan");
        step();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.class_valid) pulses++;
        end
        checks++;
        if (pulses !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scan pulses=%0d busy=%0b want 0 0", pulses, bus.busy);
        end
        begin
            int cyc;
            spike(7);
            finish_frame(cyc);
            check_result("after_reset_frame", 11, cyc, 7, 1);
        end
    endtask

    initial begin
        bus.frame_start      = 1'b0;
        bus.frame_done       = 1'b0;
        bus.packet_out       = '0;
        bus.packet_out_valid = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_dup_range();
        test_late();
        test_back_to_back();
        test_start_with_spike();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
